com_fw_to_dut_arb: RTL



---
 rtl/cms_pix28_package.sv | 38 +++
 rtl/com_in_sync.sv | 36 +++
 rtl/com_fw_to_dut_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cms_pix28_package.sv
// Shared pix28 definitions: firmware channel IDs, DUT pin map constants and
// the firmware-to-DUT arbiter state type.
package cms_pix28_package;

  typedef enum logic [1:0] {
    FW_ARB_IDLE,
    FW_ARB_GUARD,
    FW_ARB_ACTIVE
  } fw_arb_state_t;

  localparam int unsigned FW_NUM     = 4;
  localparam int unsigned FW_ID_W    = $clog2(FW_NUM + 1);
  localparam int unsigned FW_ID_NONE = 0;

  // Encoded owner IDs; 0 is reserved for "no owner"
  localparam logic [FW_ID_W-1:0] firmware_id_sc_cfg  = FW_ID_W'(1);
  localparam logic [FW_ID_W-1:0] firmware_id_sc_scan = FW_ID_W'(2);
  localparam logic [FW_ID_W-1:0] firmware_id_readout = FW_ID_W'(3);
  localparam logic [FW_ID_W-1:0] firmware_id_test    = FW_ID_W'(4);

  localparam int unsigned PIX28_NUM_OUT = 10;
  localparam int unsigned PIX28_NUM_IN  = 7;

  // reset_not and config_load idle high
  localparam logic [PIX28_NUM_OUT-1:0] PIX28_SAFE_DEFAULT = 10'b0000010100;
  localparam logic [PIX28_NUM_OUT-1:0] PIX28_FIXED_MASK   = 10'b0001100010;

  // Pin p owner lives at [p*FW_ID_W +: FW_ID_W]; only FIXED_MASK pins are used
  localparam logic [PIX28_NUM_OUT*FW_ID_W-1:0] PIX28_FIXED_OWNER = {
    FW_ID_W'(0), FW_ID_W'(0), FW_ID_W'(0),
    firmware_id_test,
    firmware_id_sc_scan,
    FW_ID_W'(0), FW_ID_W'(0), FW_ID_W'(0),
    firmware_id_sc_cfg,
    FW_ID_W'(0)
  };

endpackage

// File: rtl/com_in_sync.sv
// WIDTH x STAGES input synchroniser; the first stage is packed into the IOB.
module com_in_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  (* IOB = "TRUE" *) logic [WIDTH-1:0] r_iob;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_iob <= '0;
    else          r_iob <= i_d;
  end

  if (STAGES > 1) begin : g_chain
    logic [WIDTH-1:0] r_tail [STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int unsigned i = 0; i < STAGES - 1; i++) r_tail[i] <= '0;
      end else begin
        r_tail[0] <= r_iob;
        for (int unsigned i = 1; i < STAGES - 1; i++) r_tail[i] <= r_tail[i-1];
      end
    end

    assign o_q = r_tail[STAGES-2];
  end else begin : g_single
    assign o_q = r_iob;
  end

endmodule

// File: rtl/com_fw_to_dut_arb.sv
// Routes one of NUM_FW firmware channels to the DUT pins, with a guard period
// of safe pin values on every ownership change.
module com_fw_to_dut_arb
  import cms_pix28_package::*;
#(
  parameter int unsigned          NUM_FW         = 4,
  parameter int unsigned          NUM_OUT        = 10,
  parameter int unsigned          NUM_IN         = 7,
  parameter logic [NUM_OUT-1:0]   SAFE_DEFAULT   = PIX28_SAFE_DEFAULT,
  parameter int unsigned          GUARD_CYCLES   = 16,
  parameter int unsigned          IN_SYNC_STAGES = 2,
  parameter logic [NUM_OUT-1:0]   FIXED_MASK     = PIX28_FIXED_MASK,
  localparam int unsigned         ID_W           = $clog2(NUM_FW + 1),
  parameter logic [NUM_OUT*ID_W-1:0] FIXED_OWNER = PIX28_FIXED_OWNER
) (
  input  logic                      iob_clk,
  input  logic                      reset_n,
  input  logic [ID_W-1:0]           fw_dev_id_enable,
  input  logic [NUM_FW*NUM_OUT-1:0] fw_out,
  output logic [NUM_FW*NUM_IN-1:0]  fw_in,
  output logic [NUM_OUT-1:0]        dut_out,
  input  logic [NUM_IN-1:0]         dut_in,
  output logic [ID_W-1:0]           active_id,
  output logic                      switch_busy,
  output logic [7:0]                switch_count
);

  localparam logic [ID_W-1:0] ID_NONE    = ID_W'(FW_ID_NONE);
  localparam logic [ID_W-1:0] MAX_ID     = ID_W'(NUM_FW);
  localparam logic [7:0]      GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  fw_arb_state_t r_state, w_state_nxt;
  logic [ID_W-1:0] r_req_q, w_req;
  logic [ID_W-1:0] r_target_id, w_target_nxt;
  logic [ID_W-1:0] r_active_id, w_active_nxt;
  logic [7:0]      r_guard_cnt, w_cnt_nxt;
  logic [7:0]      r_switch_count, w_count_nxt;

  (* IOB = "TRUE" *) logic [NUM_OUT-1:0] r_dut_out;
  logic [NUM_OUT-1:0]        w_act_vec;
  logic [NUM_OUT-1:0]        w_dut_nxt;
  logic [NUM_FW*NUM_IN-1:0]  r_fw_in;
  logic [NUM_IN-1:0]         w_sync;

  assign w_req = (fw_dev_id_enable <= MAX_ID) ? fw_dev_id_enable : ID_NONE;

  always_ff @(posedge iob_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_q        <= ID_NONE;
      r_state        <= FW_ARB_IDLE;
      r_target_id    <= ID_NONE;
      r_active_id    <= ID_NONE;
      r_guard_cnt    <= '0;
      r_switch_count <= '0;
    end else begin
      r_req_q        <= w_req;
      r_state        <= w_state_nxt;
      r_target_id    <= w_target_nxt;
      r_active_id    <= w_active_nxt;
      r_guard_cnt    <= w_cnt_nxt;
      r_switch_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target_id;
    w_active_nxt = r_active_id;
    w_cnt_nxt    = r_guard_cnt;
    w_count_nxt  = r_switch_count;
    unique case (r_state)
      FW_ARB_IDLE: begin
        if (r_req_q != ID_NONE) begin
          w_state_nxt  = FW_ARB_GUARD;
          w_target_nxt = r_req_q;
          w_cnt_nxt    = GUARD_LOAD;
        end
      end
      FW_ARB_GUARD: begin
        // A changed request restarts the full guard window
        if (r_req_q != r_target_id) begin
          w_target_nxt = r_req_q;
          w_cnt_nxt    = GUARD_LOAD;
        end else if (r_guard_cnt == 8'd0) begin
          if (r_target_id != ID_NONE) begin
            w_state_nxt  = FW_ARB_ACTIVE;
            w_active_nxt = r_target_id;
            if (r_switch_count != 8'hFF) w_count_nxt = r_switch_count + 8'd1;
          end else begin
            w_state_nxt = FW_ARB_IDLE;
          end
        end else begin
          w_cnt_nxt = r_guard_cnt - 8'd1;
        end
      end
      FW_ARB_ACTIVE: begin
        if (r_req_q != r_active_id) begin
          w_state_nxt  = FW_ARB_GUARD;
          w_target_nxt = r_req_q;
          w_cnt_nxt    = GUARD_LOAD;
          w_active_nxt = ID_NONE;
        end
      end
      default: begin
        w_state_nxt = FW_ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    w_act_vec = SAFE_DEFAULT;
    for (int unsigned k = 0; k < NUM_FW; k++) begin
      if (r_state == FW_ARB_ACTIVE && r_active_id == ID_W'(k + 1))
        w_act_vec = fw_out[k*NUM_OUT +: NUM_OUT];
    end
    // Fixed pins ignore the arbiter; an unmapped fixed pin drives 0
    w_dut_nxt = w_act_vec & ~FIXED_MASK;
    for (int unsigned p = 0; p < NUM_OUT; p++) begin
      if (FIXED_MASK[p]) begin
        for (int unsigned k = 0; k < NUM_FW; k++) begin
          if (FIXED_OWNER[p*ID_W +: ID_W] == ID_W'(k + 1))
            w_dut_nxt[p] = fw_out[k*NUM_OUT + p];
        end
      end
    end
  end

  always_ff @(posedge iob_clk or negedge reset_n) begin
    if (!reset_n) r_dut_out <= SAFE_DEFAULT & ~FIXED_MASK;
    else          r_dut_out <= w_dut_nxt;
  end

  com_in_sync #(
    .WIDTH  (NUM_IN),
    .STAGES (IN_SYNC_STAGES)
  ) u_in_sync (
    .i_clk   (iob_clk),
    .i_rst_n (reset_n),
    .i_d     (dut_in),
    .o_q     (w_sync)
  );

  always_ff @(posedge iob_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fw_in <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_FW; k++)
        r_fw_in[k*NUM_IN +: NUM_IN] <=
          (r_state == FW_ARB_ACTIVE && r_active_id == ID_W'(k + 1)) ? w_sync : '0;
    end
  end

  assign dut_out      = r_dut_out;
  assign fw_in        = r_fw_in;
  assign active_id    = r_active_id;
  assign switch_busy  = (r_state == FW_ARB_GUARD);
  assign switch_count = r_switch_count;

endmodule
